// File: rtl/matrix_column_feeder.sv
// matrix_column_feeder
// Streams 7-bit LED columns for a 5x7 matrix driver. A small message buffer of
// character codes is expanded through a 5-column glyph ROM, with blank gap
// columns inserted after each glyph; the message loops while run is high.
module matrix_column_feeder #(
    parameter int MSG_DEPTH = 8,
    parameter int GAP_COLS  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         run,
    input  logic [$clog2(MSG_DEPTH):0]   msg_len,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
    input  logic [3:0]                   wr_char,
    output logic [6:0]                   prox_col,
    output logic                         busy,
    output logic [$clog2(MSG_DEPTH)-1:0] char_pos,
    output logic                         wrap
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam logic [AW:0] DEPTH_W  = (AW+1)'(MSG_DEPTH);
    localparam logic [1:0]  GAP_LAST = (GAP_COLS > 0) ? 2'(GAP_COLS - 1) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GLYPH,
        S_GAP
    } state_t;

    state_t          state_q;
    logic [2:0]      col_q;
    logic [1:0]      gap_q;
    logic [AW-1:0]   char_pos_q;
    logic [AW:0]     len_q;
    logic [6:0]      prox_col_q;
    logic            busy_q;
    logic            wrap_q;
    logic [3:0]      msg_q [MSG_DEPTH];

    logic [AW:0]     eff_len;
    logic [6:0]      glyph_col;
    logic            advance;
    logic            last_char;

    // Glyph ROM: one 7-bit column per (code, column); bit 6 is the top row.
    function automatic logic [6:0] rom_col(input logic [3:0] code, input logic [2:0] col);
        logic [34:0] g;
        case (code)
            4'd0:    g = {7'h3E, 7'h45, 7'h49, 7'h51, 7'h3E};
            4'd1:    g = {7'h00, 7'h21, 7'h7F, 7'h01, 7'h00};
            4'd2:    g = {7'h21, 7'h43, 7'h45, 7'h49, 7'h31};
            4'd3:    g = {7'h42, 7'h41, 7'h51, 7'h69, 7'h46};
            4'd4:    g = {7'h0C, 7'h14, 7'h24, 7'h7F, 7'h04};
            4'd5:    g = {7'h72, 7'h51, 7'h51, 7'h51, 7'h4E};
            4'd6:    g = {7'h1E, 7'h29, 7'h49, 7'h49, 7'h06};
            4'd7:    g = {7'h40, 7'h47, 7'h48, 7'h50, 7'h60};
            4'd8:    g = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
            4'd9:    g = {7'h30, 7'h49, 7'h49, 7'h4A, 7'h3C};
            4'd10:   g = {7'h3F, 7'h48, 7'h48, 7'h48, 7'h3F};
            4'd11:   g = {7'h7F, 7'h09, 7'h11, 7'h11, 7'h0E};
            4'd12:   g = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
            4'd13:   g = {7'h0E, 7'h11, 7'h11, 7'h09, 7'h7F};
            4'd14:   g = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
            default: g = 35'd0;
        endcase
        case (col)
            3'd0:    return g[34:28];
            3'd1:    return g[27:21];
            3'd2:    return g[20:14];
            3'd3:    return g[13:7];
            3'd4:    return g[6:0];
            default: return 7'h00;
        endcase
    endfunction

    // Effective length, column lookup and end-of-character detection.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        eff_len   = (msg_len > DEPTH_W) ? DEPTH_W : msg_len;
        glyph_col = rom_col(msg_q[char_pos_q], col_q);
        last_char = ({1'b0, char_pos_q} == (len_q - (AW+1)'(1)));
        advance   = 1'b0;
        if (run && tick) begin
            if (state_q == S_GLYPH && col_q == 3'd4 && GAP_COLS == 0)
                advance = 1'b1;
            else if (state_q == S_GAP && gap_q == GAP_LAST)
                advance = 1'b1;
        end
    end

    // Message buffer: writable in any state, all entries blank after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this buffer is reset on purpose so a fresh stream shows blanks, not garbage.
            for (int i = 0; i < MSG_DEPTH; i++) msg_q[i] <= 4'd15;
        end else if (wr_en) begin
            msg_q[wr_addr] <= wr_char;
        end
    end

    // Column sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= S_IDLE;
            col_q      <= 3'd0;
            gap_q      <= 2'd0;
            char_pos_q <= '0;
            len_q      <= '0;
            prox_col_q <= 7'h00;
            busy_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    prox_col_q <= 7'h00;
                    if (run && eff_len != '0) begin
                        state_q    <= S_GLYPH;
                        busy_q     <= 1'b1;
                        len_q      <= eff_len;
                        char_pos_q <= '0;
                        col_q      <= 3'd0;
                        gap_q      <= 2'd0;
                    end
                end
                default: begin
                    if (!run) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        prox_col_q <= 7'h00;
                        char_pos_q <= '0;
                        col_q      <= 3'd0;
                        gap_q      <= 2'd0;
                    end else if (tick) begin
                        if (state_q == S_GLYPH) begin
                            prox_col_q <= glyph_col;
                            if (col_q != 3'd4) begin
                                col_q <= col_q + 3'd1;
                            end else begin
                                col_q <= 3'd0;
                                if (GAP_COLS > 0) begin
                                    state_q <= S_GAP;
                                    gap_q   <= 2'd0;
                                end
                            end
                        end else begin
                            prox_col_q <= 7'h00;
                            if (gap_q == GAP_LAST) begin
                                state_q <= S_GLYPH;
                                gap_q   <= 2'd0;
                            end else begin
                                gap_q <= gap_q + 2'd1;
                            end
                        end
                    end
                end
            endcase

            // Move to the next character; at the end of a pass wrap and relatch the length.
            if (advance) begin
                if (last_char) begin
                    char_pos_q <= '0;
                    wrap_q     <= 1'b1;
                    len_q      <= eff_len;
                    if (eff_len == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end else begin
                    char_pos_q <= char_pos_q + AW'(1);
                end
            end
        end
    end

    assign prox_col = prox_col_q;
    assign busy     = busy_q;
    assign char_pos = char_pos_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_matrix_column_feeder.sv
// Directed testbench for matrix_column_feeder (MSG_DEPTH=8, GAP_COLS=1).
module tb_matrix_column_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       run;
    logic [3:0] msg_len;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_char;
    logic [6:0] prox_col;
    logic       busy;
    logic [2:0] char_pos;
    logic       wrap;

    int tests  = 0;
    int failed = 0;

    matrix_column_feeder #(.MSG_DEPTH(8), .GAP_COLS(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .run      (run),
        .msg_len  (msg_len),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_char  (wr_char),
        .prox_col (prox_col),
        .busy     (busy),
        .char_pos (char_pos),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input string tag, input logic [6:0] exp_col, input logic exp_wrap);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check({tag, ".col"}, 32'(prox_col), 32'(exp_col));
        check({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
    endtask

    task automatic write_char(input logic [2:0] a, input logic [3:0] c);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_char = c;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        logic [6:0] one_seq [7];
        one_seq = '{7'h00, 7'h21, 7'h7F, 7'h01, 7'h00, 7'h00, 7'h00};

        rst = 1'b0; tick = 1'b0; run = 1'b0; msg_len = 4'd0;
        wr_en = 1'b0; wr_addr = 3'd0; wr_char = 4'd0;

        // Reset state
        #12;
        check("rst.col",  32'(prox_col), 32'h00);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.pos",  32'(char_pos), 32'd0);
        check("rst.wrap", 32'(wrap), 32'd0);
        rst = 1'b1;
        step();

        // Ticks while run=0 are ignored
        for (int i = 0; i < 3; i++) begin
            do_tick("idle_tick", 7'h00, 1'b0);
            check("idle_tick.busy", 32'(busy), 32'd0);
        end

        // Glyph '1', L=1, one gap column: 00,21,7F,01,00,00 then wrap, 00
        write_char(3'd0, 4'd1);
        msg_len = 4'd1;
        run     = 1'b1;
        step();
        check("start.busy", 32'(busy), 32'd1);
        check("start.col",  32'(prox_col), 32'h00);
        for (int i = 0; i < 7; i++)
            do_tick($sformatf("one.t%0d", i + 1), one_seq[i], (i == 5));
        step();
        check("one.wrap_clear", 32'(wrap), 32'd0);
        check("one.hold", 32'(prox_col), 32'h00);

        // Advance to column 2, then drop run together with a tick
        do_tick("pre_drop", 7'h21, 1'b0);
        tick = 1'b1;
        run  = 1'b0;
        step();
        tick = 1'b0;
        check("drop.col",  32'(prox_col), 32'h00);
        check("drop.busy", 32'(busy), 32'd0);
        check("drop.pos",  32'(char_pos), 32'd0);
        run = 1'b1;
        step();
        check("restart.busy", 32'(busy), 32'd1);
        check("restart.pos",  32'(char_pos), 32'd0);
        do_tick("restart.c0", 7'h00, 1'b0);
        do_tick("restart.c1", 7'h21, 1'b0);
        do_tick("restart.c2", 7'h7F, 1'b0);

        // Asynchronous reset mid-stream while showing 7F
        #2;
        rst = 1'b0;
        #1;
        check("mrst.col",  32'(prox_col), 32'h00);
        check("mrst.busy", 32'(busy), 32'd0);
        check("mrst.pos",  32'(char_pos), 32'd0);
        rst = 1'b1;
        step();
        check("mrst.restart_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++)
            do_tick($sformatf("blank.t%0d", i + 1), 7'h00, (i == 5));

        // Three characters {1,15,1}; overwrite the third while the second is emitted
        run = 1'b0;
        step();
        write_char(3'd0, 4'd1);
        write_char(3'd1, 4'd15);
        write_char(3'd2, 4'd1);
        msg_len = 4'd3;
        run     = 1'b1;
        step();
        for (int i = 0; i < 6; i++)
            do_tick($sformatf("m3.c0.t%0d", i + 1), one_seq[i], 1'b0);
        check("m3.pos1", 32'(char_pos), 32'd1);
        write_char(3'd2, 4'd15);
        for (int i = 0; i < 6; i++)
            do_tick($sformatf("m3.c1.t%0d", i + 1), 7'h00, 1'b0);
        check("m3.pos2", 32'(char_pos), 32'd2);
        for (int i = 0; i < 6; i++)
            do_tick($sformatf("m3.c2.t%0d", i + 1), 7'h00, (i == 5));
        check("m3.pos_wrap", 32'(char_pos), 32'd0);

        // msg_len=0 keeps the block idle
        run = 1'b0;
        step();
        msg_len = 4'd0;
        run     = 1'b1;
        step();
        step();
        check("len0.busy", 32'(busy), 32'd0);
        do_tick("len0.tick", 7'h00, 1'b0);
        check("len0.busy2", 32'(busy), 32'd0);

        // msg_len=12 clamps to 8: char_pos cycles 0..7, wrap every 8 characters
        msg_len = 4'd12;
        step();
        check("len12.busy", 32'(busy), 32'd1);
        for (int c = 0; c < 16; c++) begin
            check($sformatf("len12.pos%0d", c), 32'(char_pos), 32'(c % 8));
            for (int t = 0; t < 6; t++) begin
                tick = 1'b1;
                step();
                tick = 1'b0;
                check($sformatf("len12.c%0d.t%0d.wrap", c, t), 32'(wrap),
                      32'((c % 8 == 7) && (t == 5)));
            end
        end
        check("len12.final_pos", 32'(char_pos), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/matrix_column_feeder.md
# matrix_column_feeder

Produces the column stream consumed by the 5x7 LED matrix driver on its `prox_col` input. It holds a short message of character codes and expands each one through an internal 5-column glyph ROM. On every advance strobe it emits the next 7-bit column, and it inserts blank gap columns between characters. The message loops continuously while enabled. The block sits between the control logic that writes the message and the matrix driver, and runs in the same clock domain as the driver's shift tick.

## Interface
- `MSG_DEPTH`, 8: message buffer entries (power of two, ≥2).
- `GAP_COLS`, 1: blank columns after each glyph (0–3).
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  column-advance strobe; one `clk` cycle wide per shift (driver's 6 Hz rate).
- `run`  in  1  level enable for streaming.
- `msg_len`  in  clog2(MSG_DEPTH)+1  number of characters to loop over.
- `wr_en`  in  1  message write strobe.
- `wr_addr`  in  clog2(MSG_DEPTH)  message write index.
- `wr_char`  in  4  character code: 0–9 digits, 10–14 A,b,C,d,E, 15 blank.
- `prox_col`  out  7  current column; bit 6 = top row (L0), bit 0 = bottom row (L6); registered.
- `busy`  out  1  high while not IDLE.
- `char_pos`  out  clog2(MSG_DEPTH)  index of the character currently being emitted.
- `wrap`  out  1  one-cycle pulse when the final column of the final character is emitted.

## Operation
- Message buffer: MSG_DEPTH×4-bit registers.
  - Written synchronously when `wr_en`=1, in any state.
  - A write to the character currently being emitted takes effect at its next column fetch.
- Effective length: `L` = min(`msg_len`, MSG_DEPTH).
  - `L` is latched on IDLE exit and again at each wrap.
  - Changes made mid-loop apply from the next pass.
- Glyph ROM: combinational, indexed by (code, column 0–4). Mandatory contents:
  - code 15 (blank): all columns 7'h00.
  - code 1: 7'h00, 7'h21, 7'h7F, 7'h01, 7'h00.
  - All other glyphs follow the team font sheet.
- FSM states: IDLE, GLYPH, GAP. Internal counters: `col` (0–4), `gap` (0–GAP_COLS-1), `char_pos`.
  - IDLE: if `run`=1 and `L`≠0, go to GLYPH with `char_pos`=0, `col`=0. `tick` is ignored in IDLE.
  - GLYPH, on `tick`:
    - `prox_col` ← ROM(buf[`char_pos`], `col`).
    - If `col`<4: `col`++.
    - If `col`=4 and GAP_COLS>0: `col`←0, go to GAP.
    - If `col`=4 and GAP_COLS=0: advance to the next character.
  - GAP, on `tick`:
    - `prox_col` ← 7'h00.
    - On the last gap column: advance to the next character.
  - Advance to the next character:
    - If `char_pos`=`L`−1: `char_pos`←0, pulse `wrap`, relatch `L`.
    - Otherwise: `char_pos`++.
- `wrap` is asserted in the same cycle `prox_col` shows the last column of the pass:
  - the last gap column when GAP_COLS>0;
  - glyph column 4 when GAP_COLS=0.
- `run`=0 in any non-IDLE state returns the block to IDLE on the next edge:
  - `prox_col`←0, counters cleared, no `wrap` pulse.
  - `run` falling has priority over a simultaneous `tick`.
- `L`=0 while `run`=1: the block stays in IDLE with outputs at 0.

## Timing
- Reset (asynchronous, `rst`=0):
  - `prox_col`=0, `busy`=0, `char_pos`=0, `wrap`=0.
  - State IDLE; all buffer entries = 15 (blank).
- `busy` rises one cycle after `run` rises (with `L`≠0). No column is emitted until the first `tick` after that.
- Latency: `prox_col` changes exactly one `clk` edge after the cycle in which `tick` is sampled high. Between ticks, `prox_col` holds.
- Consecutive `tick` cycles are legal; each one advances exactly one column.
- `rst` asserted mid-stream clears everything immediately; a new stream restarts from character 0, column 0.

## Test plan
- Reset mid-stream with `prox_col`=7'h7F → `prox_col`=0, `busy`=0, `char_pos`=0; buffer reads back blank (streaming with `L`=1 yields only 7'h00 columns).
- buf[0]=1, `msg_len`=1, GAP_COLS=1, `run`=1, 7 ticks → `prox_col` sequence 00,21,7F,01,00,00,00; `wrap` pulses only on tick 6.
- `tick` pulses with `run`=0 → `prox_col` stays 0, `busy`=0, `wrap` never asserts.
- `run` dropped in the same cycle as a tick during glyph column 2 → next cycle `prox_col`=0, `busy`=0; re-enabling restarts at `char_pos`=0, column 0.
- `msg_len`=3, buf={1,15,1}; write buf[2]=15 while `char_pos`=1 → the third character emits all 7'h00.
- `msg_len`=0 → stays IDLE. `msg_len`=12 with MSG_DEPTH=8 → `char_pos` cycles 0–7 and `wrap` occurs every 8 characters.
